exception_request_arbiter: RTL
==============================

// Module: exception_request_arbiter
// PURPOSE
//  Collects external exception sources (push-buttons / peripherals), synchronises and edge-detects
//  them, applies a software mask and fixed priority, and presents one request at a time to the CPU
//  exception path. Tracks in-service levels so higher-priority sources can preempt lower ones.
//  Sits between the board exception inputs and CP0, which consumes irq_req/irq_id and returns ack/eret.
// PARAMETERS
//  NUM_SRC      3   number of exception sources; index 0 = highest priority
//  SYNC_STAGES  2   synchroniser flops per source (>=2)
//  NEST_EN      1   1: higher-priority source may preempt an in-service one; 0: one at a time
// PORTS
//  clk          in   1              system clock, sole clock domain
//  reset        in   1              synchronous, active-high
//  exp_src      in   NUM_SRC        raw asynchronous exception inputs, rising edge = event
//  mask_we      in   1              write strobe for mask register
//  mask_wdata   in   NUM_SRC        new mask; bit=1 blocks source
//  halt         in   1              syscall halt; blocks new requests
//  irq_ack      in   1              CPU took the exception this cycle
//  eret         in   1              CPU executed eret this cycle
//  irq_req      out  1              exception request to CPU
//  irq_id       out  $clog2(NUM_SRC) index of requesting source
//  mask         out  NUM_SRC        current mask register
//  pending      out  NUM_SRC        latched, not-yet-acknowledged events
//  in_service   out  NUM_SRC        acknowledged, not-yet-returned levels
//  nest_depth   out  $clog2(NUM_SRC+1) popcount(in_service)
//  spurious     out  1              1-cycle pulse: ack outside REQ, or eret with in_service==0
// BEHAVIOUR
//  Reset (sync): all outputs 0, mask=0 (all enabled), sync/edge flops 0, FSM=IDLE.
//  Input path: SYNC_STAGES flops, then rise = sync & ~prev. rise[i] sets pending[i].
//   Pin edge -> pending visible SYNC_STAGES+1 cycles later; level held high = one event only.
//  Eligibility: elig = pending & ~mask & prio_ok. prio_ok[i] = no in_service bit j<=i.
//   NEST_EN=0: elig forced 0 unless in_service==0. Winner = lowest index set in elig.
//  FSM states IDLE, REQ, SERVE:
//   IDLE : elig!=0 && !halt -> REQ; irq_req<=1, irq_id<=winner (registered, 1-cycle latency).
//   REQ  : irq_req/irq_id held stable until irq_ack; later higher-priority events, mask writes and
//          halt do NOT change or withdraw the request. On irq_ack: pending[id]<=0,
//          in_service[id]<=1, irq_req<=0 -> SERVE.
//   SERVE: eret -> clear lowest-index (highest-priority) in_service bit; if result==0 -> IDLE.
//          else if elig!=0 && !halt -> REQ (preemption, winner as in IDLE).
//          eret and elig same cycle: eret processed, eligibility re-evaluated next cycle.
//  Simultaneous rise[i] and ack-clear of pending[i]: set wins (new event kept).
//  mask_we: mask updates next cycle; masked pending bits retained, not cleared.
//  irq_ack outside REQ: ignored, spurious pulses. eret with in_service==0: ignored, spurious pulses.
//  irq_ack and eret same cycle: ack handled, eret flagged spurious (CPU cannot do both).
//  halt: sticky externally; a request already in REQ still completes its handshake.
//  nest_depth combinational from in_service; all other outputs registered.
// STRUCTURE
//  Package exc_arb_pkg: state enum {IDLE,REQ,SERVE}; ID_W function; default NUM_SRC.
//  Sub-module edge_sync_detect (per source, generate loop): synchroniser + rising-edge pulse.
//  Top: mask reg, pending/in_service regs, priority encoder function, FSM.
// TESTING
//  1 Reset mid-REQ (irq_req=1, id=1) -> next cycle irq_req=0, pending=0, in_service=0, FSM IDLE.
//  2 Pulse exp_src[2] one cycle -> pending=3'b100 after 3 clk, irq_req=1,id=2 next clk; ack ->
//    in_service=3'b100, pending=0; eret -> in_service=0, irq_req stays 0.
//  3 exp_src=3'b110 same cycle -> id=1 first; ack; NEST_EN=1 -> immediate REQ id... none (2 lower);
//    eret -> REQ id=2; ack; eret -> IDLE, nest_depth 0.
//  4 NEST_EN=1: serving id=2, pulse exp_src[0] -> REQ id=0, ack -> in_service=3'b101, depth=2;
//    eret clears bit0 only; second eret clears bit2 -> IDLE. NEST_EN=0: no REQ until first eret.
//  5 mask=3'b001, pulse src0 -> pending=001, irq_req stays 0; mask=0 -> irq_req=1,id=0 2 clk later.
//  6 halt=1 with pending -> no request; irq_ack in IDLE -> spurious=1 one cycle, state unchanged;
//    exp_src held high 20 cycles -> exactly one pending event.

Source files
------------

// File: rtl/exception_request_arbiter_pkg.sv
// rtl/exception_request_arbiter_pkg.sv - shared types and sizing helpers for the exception arbiter
package exc_arb_pkg;

    localparam int DEFAULT_NUM_SRC = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } arb_state_t;

    // Width of a source index; never below one bit so a single source still has an id field.
    function automatic int id_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/exception_request_arbiter_if.sv
// rtl/exception_request_arbiter_if.sv - request/acknowledge handshake between arbiter and CP0
interface exception_request_arbiter_if #(
    parameter int NUM_SRC = exc_arb_pkg::DEFAULT_NUM_SRC
);
    import exc_arb_pkg::*;

    localparam int ID_W = id_w(NUM_SRC);

    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            eret;

    modport master (output irq_req, output irq_id, input irq_ack, input eret);
    modport slave  (input irq_req, input irq_id, output irq_ack, output eret);

endinterface

// File: rtl/exception_request_arbiter_edge_sync_detect.sv
// rtl/exception_request_arbiter_edge_sync_detect.sv - synchroniser plus rising-edge pulse for one source
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exception_request_arbiter.sv
// rtl/exception_request_arbiter.sv - masked fixed-priority exception arbiter with nesting
module exception_request_arbiter
    import exc_arb_pkg::*;
#(
    parameter int NUM_SRC     = DEFAULT_NUM_SRC,
    parameter int SYNC_STAGES = 2,
    parameter int NEST_EN     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           exp_src,
    input  logic                         mask_we,
    input  logic [NUM_SRC-1:0]           mask_wdata,
    input  logic                         halt,
    exception_request_arbiter_if.master  cpu,
    output logic [NUM_SRC-1:0]           mask,
    output logic [NUM_SRC-1:0]           pending,
    output logic [NUM_SRC-1:0]           in_service,
    output logic [$clog2(NUM_SRC+1)-1:0] nest_depth,
    output logic                         spurious
);

    localparam int ID_W    = id_w(NUM_SRC);
    localparam int DEPTH_W = $clog2(NUM_SRC + 1);

    arb_state_t         state_q, state_n;
    logic [NUM_SRC-1:0] rise, prio_ok, elig, lowest_is, in_service_after, ack_onehot;
    logic [ID_W-1:0]    winner;
    logic               seen, ack_fire, eret_valid, load_req, spurious_d;

    function automatic logic [ID_W-1:0] first_set(input logic [NUM_SRC-1:0] vec);
        first_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) first_set = ID_W'(i);
        end
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (exp_src[g]),
            .rise     (rise[g])
        );
    end

    // A source is only eligible when no equal-or-higher priority level is currently in service.
    always_comb begin
        seen    = 1'b0;
        prio_ok = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            seen       = seen | in_service[i];
            prio_ok[i] = ~seen;
        end
        elig = pending & ~mask & prio_ok;
        if (NEST_EN == 0 && in_service != '0) elig = '0;
    end

    assign winner           = first_set(elig);
    assign lowest_is        = in_service & ~(in_service - NUM_SRC'(1));
    assign in_service_after = in_service & ~lowest_is;
    assign ack_onehot       = ack_fire ? (NUM_SRC'(1) << cpu.irq_id) : '0;

    always_comb begin
        nest_depth = '0;
        for (int i = 0; i < NUM_SRC; i++) nest_depth = nest_depth + DEPTH_W'(in_service[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (elig != '0 && !halt) state_n = REQ;
            REQ:     if (cpu.irq_ack) state_n = SERVE;
            SERVE: begin
                // An eret takes the whole cycle; preemption is re-evaluated on the next one.
                if (cpu.eret) begin
                    if (in_service_after == '0) state_n = IDLE;
                end else if (elig != '0 && !halt) begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_fire   = (state_q == REQ) && cpu.irq_ack;
        eret_valid = cpu.eret && (in_service != '0) && !ack_fire;
        load_req   = (state_q != REQ) && (state_n == REQ);
        spurious_d = (cpu.irq_ack && state_q != REQ) || (cpu.eret && !eret_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask        <= '0;
            pending     <= '0;
            in_service  <= '0;
            cpu.irq_req <= 1'b0;
            cpu.irq_id  <= '0;
            spurious    <= 1'b0;
        end else begin
            if (mask_we) mask <= mask_wdata;
            // New edge wins over the acknowledge clear of the same bit.
            pending <= (pending & ~ack_onehot) | rise;
            if (ack_fire)        in_service <= in_service | ack_onehot;
            else if (eret_valid) in_service <= in_service_after;
            if (load_req) begin
                cpu.irq_req <= 1'b1;
                cpu.irq_id  <= winner;
            end else if (ack_fire) begin
                cpu.irq_req <= 1'b0;
            end
            spurious <= spurious_d;
        end
    end

endmodule
